decode_alu_pc_unit: RTL and testbench

DECODE_ALU_PC_UNIT -- requirements
Module: decode_alu_pc_unit

---
 rtl/decode_alu_pc_unit_pkg.sv | 48 ++++
 rtl/decode_alu_pc_unit_instr_decode.sv | 104 ++++++++++
 rtl/decode_alu_pc_unit.sv | 119 +++++++++++
 tb/tb_decode_alu_pc_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_alu_pc_unit_pkg.sv
// Shared opcode/funct3 constants and ALU operation type for the RV64I decode/execute unit.
package decode_alu_pc_unit_pkg;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC
   } alu_op_t;

   // Maps funct3 to an ALU op; i_alt selects SUB/SRA where bit 30 applies.
   function automatic alu_op_t base_op(input logic [2:0] i_f3, input logic i_alt);
      alu_op_t r_op;
      case (i_f3)
         F3_ADD:  r_op = i_alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  r_op = ALU_SLL;
         F3_SLT:  r_op = ALU_SLT;
         F3_SLTU: r_op = ALU_SLTU;
         F3_XOR:  r_op = ALU_XOR;
         F3_SRL:  r_op = i_alt ? ALU_SRA : ALU_SRL;
         F3_OR:   r_op = ALU_OR;
         default: r_op = ALU_AND;
      endcase
      return r_op;
   endfunction

   function automatic logic f7_alt_ok(input logic [6:0] i_f7);
      return (i_f7 == F7_ZERO) || (i_f7 == F7_ALT);
   endfunction

endpackage

// File: rtl/decode_alu_pc_unit_instr_decode.sv
// Combinational RV64I decoder: register fields, immediate, ALU op and legality.
module instr_decode
   import decode_alu_pc_unit_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic [63:0] o_imm,
   output alu_op_t     o_alu_op,
   output logic        o_use_imm,
   output logic        o_writes_rd,
   output logic        o_is_w,
   output logic        o_illegal_instr,
   output logic        o_is_halt
);

   logic [9:0] w_op10;
   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_alt;
   logic       w_is_shr;
   logic       w_legal;
   logic       w_writes;

   assign w_op10   = {i_instr[14:12], i_instr[6:0]};
   assign w_opcode = w_op10[6:0];
   assign w_funct3 = w_op10[9:7];
   assign w_funct7 = i_instr[31:25];
   assign w_alt    = i_instr[30];
   assign w_is_shr = (w_funct3 == F3_SRL);

   assign o_rs1 = i_instr[19:15];
   assign o_rs2 = i_instr[24:20];
   assign o_rd  = i_instr[11:7];

   always_comb begin
      o_imm     = {{52{i_instr[31]}}, i_instr[31:20]};
      o_alu_op  = ALU_ADD;
      o_use_imm = 1'b0;
      o_is_w    = 1'b0;
      w_writes  = 1'b0;
      w_legal   = 1'b0;
      case (w_opcode)
         OPC_OP_IMM: begin
            o_use_imm = 1'b1;
            w_writes  = 1'b1;
            // Immediate bit 30 is only a function selector for the right shifts.
            o_alu_op  = base_op(w_funct3, w_alt & w_is_shr);
            case (w_funct3)
               F3_SLL:  w_legal = (i_instr[31:26] == 6'b000000);
               F3_SRL:  w_legal = (i_instr[31:26] == 6'b000000) || (i_instr[31:26] == 6'b010000);
               default: w_legal = 1'b1;
            endcase
         end
         OPC_OP: begin
            w_writes = 1'b1;
            o_alu_op = base_op(w_funct3, w_alt);
            if (w_funct3 == F3_ADD || w_is_shr)
               w_legal = f7_alt_ok(w_funct7);
            else
               w_legal = (w_funct7 == F7_ZERO);
         end
         OPC_OP_IMM_32: begin
            o_use_imm = 1'b1;
            o_is_w    = 1'b1;
            w_writes  = 1'b1;
            o_alu_op  = base_op(w_funct3, w_alt & w_is_shr);
            case (w_funct3)
               F3_ADD:  w_legal = 1'b1;
               F3_SLL:  w_legal = (w_funct7 == F7_ZERO);
               F3_SRL:  w_legal = f7_alt_ok(w_funct7);
               default: w_legal = 1'b0;
            endcase
         end
         OPC_OP_32: begin
            o_is_w   = 1'b1;
            w_writes = 1'b1;
            o_alu_op = base_op(w_funct3, w_alt);
            case (w_funct3)
               F3_ADD:  w_legal = f7_alt_ok(w_funct7);
               F3_SLL:  w_legal = (w_funct7 == F7_ZERO);
               F3_SRL:  w_legal = f7_alt_ok(w_funct7);
               default: w_legal = 1'b0;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            o_imm     = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
            o_use_imm = 1'b1;
            w_writes  = 1'b1;
            w_legal   = 1'b1;
            o_alu_op  = (w_opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
         end
         default: ;
      endcase
   end

   // Halt encoding takes precedence over every other classification.
   assign o_is_halt       = (i_instr[7:0] == 8'h00);
   assign o_illegal_instr = ~w_legal & ~o_is_halt;
   assign o_writes_rd     = w_writes & w_legal & ~o_is_halt;

endmodule

// File: rtl/decode_alu_pc_unit.sv
// Single-cycle RV64I integer unit: register file, ALU and program counter.
module decode_alu_pc_unit
   import decode_alu_pc_unit_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] entry,
   input  logic [XLEN-1:0] stackptr,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic            halt,
   output logic            illegal,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] r_regs [1:NREGS-1];
   logic [XLEN-1:0] r_pc;
   logic            r_halt;
   logic            r_illegal;

   logic [4:0]      w_rs1, w_rs2, w_rd;
   logic [63:0]     w_imm;
   alu_op_t         w_alu_op;
   logic            w_use_imm, w_writes_rd, w_is_w, w_illegal_instr, w_is_halt;
   logic            w_retire, w_we;
   logic [XLEN-1:0] w_a, w_b, w_res64, w_result;
   logic [31:0]     w_a32, w_b32, w_res32;
   logic [5:0]      w_sh6;
   logic [4:0]      w_sh5;

   instr_decode u_decode (
      .i_instr         (instr),
      .o_rs1           (w_rs1),
      .o_rs2           (w_rs2),
      .o_rd            (w_rd),
      .o_imm           (w_imm),
      .o_alu_op        (w_alu_op),
      .o_use_imm       (w_use_imm),
      .o_writes_rd     (w_writes_rd),
      .o_is_w          (w_is_w),
      .o_illegal_instr (w_illegal_instr),
      .o_is_halt       (w_is_halt)
   );

   // x0 is not stored; every read port substitutes zero for index 0.
   assign w_a       = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
   assign w_b       = w_use_imm ? w_imm : ((w_rs2 == 5'd0) ? '0 : r_regs[w_rs2]);
   assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : r_regs[dbg_raddr];

   assign w_a32 = w_a[31:0];
   assign w_b32 = w_b[31:0];
   assign w_sh6 = w_b[5:0];
   assign w_sh5 = w_b[4:0];

   always_comb begin
      w_res64 = '0;
      w_res32 = '0;
      case (w_alu_op)
         ALU_ADD:   begin w_res64 = w_a + w_b; w_res32 = w_a32 + w_b32; end
         ALU_SUB:   begin w_res64 = w_a - w_b; w_res32 = w_a32 - w_b32; end
         ALU_SLL:   begin w_res64 = w_a << w_sh6; w_res32 = w_a32 << w_sh5; end
         ALU_SRL:   begin w_res64 = w_a >> w_sh6; w_res32 = w_a32 >> w_sh5; end
         ALU_SRA:   begin w_res64 = $signed(w_a) >>> w_sh6; w_res32 = $signed(w_a32) >>> w_sh5; end
         ALU_SLT:   w_res64 = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         ALU_SLTU:  w_res64 = {{(XLEN-1){1'b0}}, (w_a < w_b)};
         ALU_XOR:   w_res64 = w_a ^ w_b;
         ALU_OR:    w_res64 = w_a | w_b;
         ALU_AND:   w_res64 = w_a & w_b;
         ALU_LUI:   w_res64 = w_b;
         ALU_AUIPC: w_res64 = r_pc + w_b;
         default:   w_res64 = '0;
      endcase
      w_result = w_is_w ? {{(XLEN-32){w_res32[31]}}, w_res32} : w_res64;
   end

   assign w_retire = instr_valid & ~r_halt;
   assign w_we     = w_retire & ~w_is_halt & w_writes_rd & (w_rd != 5'd0);

   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (reset)
               r_regs[gi] <= (gi == 2) ? stackptr : '0;
            else if (w_we && (w_rd == AW'(gi)))
               r_regs[gi] <= w_result;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= entry;
         r_halt    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         if (w_retire) begin
            if (w_is_halt) begin
               r_halt <= 1'b1;
            end else begin
               r_pc      <= r_pc + XLEN'(4);
               r_illegal <= w_illegal_instr;
            end
         end
      end
   end

   assign pc      = r_pc;
   assign halt    = r_halt;
   assign illegal = r_illegal;

endmodule

// File: tb/tb_decode_alu_pc_unit.sv
// Directed and randomized checks of decode_alu_pc_unit against an instruction-level model.
`timescale 1ns/100ps
module tb_decode_alu_pc_unit;

   localparam logic [6:0] T_OP = 7'h33, T_OPI = 7'h13, T_OP32 = 7'h3B, T_OPI32 = 7'h1B;
   localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] entry = 64'h0;
   logic [63:0] stackptr = 64'h0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = 32'h0;
   logic [63:0] pc;
   logic        halt;
   logic        illegal;
   logic [4:0]  dbg_raddr = 5'd0;
   logic [63:0] dbg_rdata;

   // Architectural model state
   logic [63:0] m_regs [32];
   logic [63:0] m_pc = 64'h0;
   bit          m_halt = 1'b0;
   bit          m_illegal = 1'b0;
   bit          m_valid = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   decode_alu_pc_unit dut (
      .clk         (clk),
      .reset       (reset),
      .entry       (entry),
      .stackptr    (stackptr),
      .instr_valid (instr_valid),
      .instr       (instr),
      .pc          (pc),
      .halt        (halt),
      .illegal     (illegal),
      .dbg_raddr   (dbg_raddr),
      .dbg_rdata   (dbg_rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Instruction semantics straight from the ISA description
   function automatic void exec(input logic [31:0] ins, input logic [63:0] pcv,
                                input logic [63:0] a, input logic [63:0] b,
                                output bit legal, output logic [63:0] val);
      logic [63:0] immi;
      logic [63:0] immu;
      logic [6:0]  opc;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [5:0]  sh6;
      logic [4:0]  sh5;
      immi  = {{52{ins[31]}}, ins[31:20]};
      immu  = {{32{ins[31]}}, ins[31:12], 12'h000};
      opc   = ins[6:0];
      f7    = ins[31:25];
      f3    = ins[14:12];
      legal = 1'b1;
      val   = 64'h0;
      case (opc)
         T_OPI: begin
            sh6 = ins[25:20];
            case (f3)
               3'd0: val = a + immi;
               3'd1: begin legal = (ins[31:26] == 6'h00); val = a << sh6; end
               3'd2: val = ($signed(a) < $signed(immi)) ? 64'd1 : 64'd0;
               3'd3: val = (a < immi) ? 64'd1 : 64'd0;
               3'd4: val = a ^ immi;
               3'd5: begin
                  if (ins[31:26] == 6'h00) val = a >> sh6;
                  else if (ins[31:26] == 6'h10) val = $signed(a) >>> sh6;
                  else legal = 1'b0;
               end
               3'd6: val = a | immi;
               default: val = a & immi;
            endcase
         end
         T_OP: begin
            sh6 = b[5:0];
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: val = a + b;
                  3'd1: val = a << sh6;
                  3'd2: val = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                  3'd3: val = (a < b) ? 64'd1 : 64'd0;
                  3'd4: val = a ^ b;
                  3'd5: val = a >> sh6;
                  3'd6: val = a | b;
                  default: val = a & b;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) val = a - b;
            else if (f7 == 7'h20 && f3 == 3'd5) val = $signed(a) >>> sh6;
            else legal = 1'b0;
         end
         T_OPI32: begin
            sh5 = ins[24:20];
            if (f3 == 3'd0) val = sext32(a[31:0] + immi[31:0]);
            else if (f3 == 3'd1 && f7 == 7'h00) val = sext32(a[31:0] << sh5);
            else if (f3 == 3'd5 && f7 == 7'h00) val = sext32(a[31:0] >> sh5);
            else if (f3 == 3'd5 && f7 == 7'h20) val = sext32($signed(a[31:0]) >>> sh5);
            else legal = 1'b0;
         end
         T_OP32: begin
            sh5 = b[4:0];
            if (f7 == 7'h00 && f3 == 3'd0) val = sext32(a[31:0] + b[31:0]);
            else if (f7 == 7'h20 && f3 == 3'd0) val = sext32(a[31:0] - b[31:0]);
            else if (f7 == 7'h00 && f3 == 3'd1) val = sext32(a[31:0] << sh5);
            else if (f7 == 7'h00 && f3 == 3'd5) val = sext32(a[31:0] >> sh5);
            else if (f7 == 7'h20 && f3 == 3'd5) val = sext32($signed(a[31:0]) >>> sh5);
            else legal = 1'b0;
         end
         T_LUI:   val = immu;
         T_AUIPC: val = pcv + immu;
         default: legal = 1'b0;
      endcase
   endfunction

   task automatic model_edge();
      bit          legal;
      logic [63:0] val;
      m_illegal = 1'b0;
      if (reset) begin
         foreach (m_regs[i]) m_regs[i] = 64'h0;
         m_regs[2] = stackptr;
         m_pc      = entry;
         m_halt    = 1'b0;
         m_valid   = 1'b1;
      end else if (instr_valid && !m_halt) begin
         if (instr[7:0] == 8'h00) begin
            m_halt = 1'b1;
         end else begin
            exec(instr, m_pc, m_regs[instr[19:15]], m_regs[instr[24:20]], legal, val);
            if (!legal) m_illegal = 1'b1;
            else if (instr[11:7] != 5'd0) m_regs[instr[11:7]] = val;
            m_pc = m_pc + 64'd4;
         end
      end
   endtask

   task automatic step(input bit rst, input bit v, input logic [31:0] ins);
      reset       = rst;
      instr_valid = v;
      instr       = ins;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [6:0]  f7;
      logic [31:0] w;
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rd = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rs1 = 5'($urandom);
      f3  = 3'($urandom);
      imm = 12'($urandom);
      case ($urandom_range(0, 5))
         0: imm = 12'h7FF;
         1: imm = 12'h800;
         2: imm = 12'hFFF;
         default: ;
      endcase
      f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 15) == 0) f7 = 7'($urandom);
      w = $urandom;
      case ($urandom_range(0, 8))
         0, 1: begin
            if (f3 == 3'd1 || f3 == 3'd5) imm = {f7[6:1], 6'($urandom)};
            w = enc_i(imm, rs1, f3, rd, T_OPI);
         end
         2, 3: w = enc_r(f7, rs2, rs1, f3, rd, T_OP);
         4: begin
            if (f3 == 3'd1 || f3 == 3'd5) imm = {f7, 5'($urandom)};
            w = enc_i(imm, rs1, f3, rd, T_OPI32);
         end
         5: w = enc_r(f7, rs2, rs1, f3, rd, T_OP32);
         6: w = enc_u(20'($urandom), rd, T_LUI);
         7: w = enc_u(20'($urandom), rd, T_AUIPC);
         default: if (w[7:0] == 8'h00) w[0] = 1'b1;
      endcase
      return w;
   endfunction

   // Per-cycle comparison of every architectural output against the model
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("pc", pc, m_pc);
            chk("halt", {63'h0, halt}, {63'h0, m_halt});
            chk("illegal", {63'h0, illegal}, {63'h0, m_illegal});
            for (int i = 0; i < 32; i++) begin
               dbg_raddr = 5'(i);
               #0.1;
               chk($sformatf("x%0d", i), dbg_rdata, (i == 0) ? 64'h0 : m_regs[i]);
            end
         end
      end
   end

   initial begin
      logic [31:0] ins;
      bit          rst, v;

      entry    = 64'h1000;
      stackptr = 64'h7FF0;
      step(1'b1, 1'b0, 32'h0);
      chk("rst_pc", pc, 64'h1000);
      chk("rst_halt", {63'h0, halt}, 64'h0);
      chk("rst_illegal", {63'h0, illegal}, 64'h0);
      chk("model_rst_sp", m_regs[2], 64'h7FF0);
      chk("model_rst_x5", m_regs[5], 64'h0);

      step(1'b0, 1'b1, enc_i(12'hFFF, 5'd0, 3'd0, 5'd5, T_OPI));
      step(1'b0, 1'b1, enc_i(12'd60, 5'd5, 3'd5, 5'd6, T_OPI));
      chk("pc_after_srli", pc, 64'h1008);
      chk("model_addi_x5", m_regs[5], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("model_srli_x6", m_regs[6], 64'hF);

      step(1'b0, 1'b1, enc_u(20'h80000, 5'd7, T_LUI));
      step(1'b0, 1'b1, enc_i(12'h000, 5'd7, 3'd0, 5'd8, T_OPI32));
      step(1'b0, 1'b1, enc_r(7'h00, 5'd7, 5'd0, 3'd3, 5'd9, T_OP));
      chk("model_lui_x7", m_regs[7], 64'hFFFF_FFFF_8000_0000);
      chk("model_addiw_x8", m_regs[8], 64'hFFFF_FFFF_8000_0000);
      chk("model_sltu_x9", m_regs[9], 64'h1);
      chk("pc_after_sltu", pc, 64'h1014);

      step(1'b0, 1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd0, T_OPI));
      chk("model_x0", m_regs[0], 64'h0);
      step(1'b0, 1'b1, 32'h0000_007F);
      chk("illegal_pulse", {63'h0, illegal}, 64'h1);
      chk("pc_after_illegal", pc, 64'h101C);
      step(1'b0, 1'b0, 32'h0);
      chk("illegal_clear", {63'h0, illegal}, 64'h0);

      step(1'b0, 1'b1, 32'h0000_0000);
      chk("halt_set", {63'h0, halt}, 64'h1);
      chk("halt_pc", pc, 64'h101C);
      step(1'b0, 1'b1, enc_i(12'd1, 5'd0, 3'd0, 5'd1, T_OPI));
      chk("halted_pc", pc, 64'h101C);
      chk("model_halted_x1", m_regs[1], 64'h0);

      step(1'b1, 1'b1, enc_i(12'd1, 5'd0, 3'd0, 5'd1, T_OPI));
      chk("rst_drop_pc", pc, 64'h1000);
      chk("rst_drop_halt", {63'h0, halt}, 64'h0);
      chk("model_rst_drop_x1", m_regs[1], 64'h0);
      step(1'b0, 1'b0, 32'h0);

      // Randomized phase, starting just below the pc wrap point
      entry    = 64'hFFFF_FFFF_FFFF_FFF0;
      stackptr = 64'h8000_0000_0000_0000;
      step(1'b1, 1'b0, 32'h0);
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 15) == 0);
         if (rst) begin
            entry    = ($urandom_range(0, 2) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                                   : {32'($urandom), 32'($urandom)} & ~64'h3;
            stackptr = {32'($urandom), 32'($urandom)};
         end
         v   = ($urandom_range(0, 9) != 0);
         ins = rand_instr();
         if ($urandom_range(0, 299) == 0) ins[7:0] = 8'h00;
         step(rst, v, ins);
      end
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
